// File: rtl/fetch_controller.sv
// Instruction fetch controller: IDLE/RUN/HALT sequencer feeding a one-entry output register.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_count transfer counter output.
module fetch_controller #(
    parameter logic [31:0] RESET_PC     = 32'h00013880,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        halted_q;
    logic        misalign_q, misalign_d;
    logic        xfer;
    logic        fetch_ok;
    logic        zero_word;

    assign xfer      = vld_q & if_ready;
    // The output slot is free when empty or when its word leaves this cycle.
    assign fetch_ok  = (state_q == RUN) && (!vld_q || if_ready);
    assign zero_word = HALT_ON_ZERO && (imem_data == 32'd0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        vld_d      = vld_q & ~if_ready;
        instr_d    = instr_q;
        ifpc_d     = ifpc_q;
        misalign_d = misalign_q | (redirect_valid & (|redirect_pc[1:0]));

        if (redirect_valid) begin
            pc_d  = {redirect_pc[31:2], 2'b00};
            vld_d = 1'b0;
            if (state_q == IDLE) begin
                state_d = start ? RUN : IDLE;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (fetch_ok) begin
                        // A zero word is swallowed and the PC parks on it.
                        if (zero_word) begin
                            state_d = HALT;
                        end else begin
                            vld_d   = 1'b1;
                            instr_d = imem_data;
                            ifpc_d  = pc_q;
                            pc_d    = pc_q + 32'd4;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            vld_q      <= 1'b0;
            instr_q    <= 32'd0;
            ifpc_q     <= 32'd0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            vld_q      <= vld_d;
            instr_q    <= instr_d;
            ifpc_q     <= ifpc_d;
            halted_q   <= (state_d == HALT);
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (xfer) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`endif

    assign imem_addr    = pc_q;
    assign if_valid     = vld_q;
    assign if_instr     = instr_q;
    assign if_pc        = ifpc_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; memory returns ~addr except a programmable zero word.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    logic        zero_en;
    logic [31:0] zero_addr;
    int          nvec;
    int          nerr;
    int unsigned xfers;

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .misalign_err   (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    assign imem_data = (zero_en && imem_addr == zero_addr) ? 32'd0 : ~imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) xfers = 0;
        else if (if_valid && if_ready) xfers = xfers + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; if_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        step();
        step();
        reset = 1'b0;
        nvec++; if (if_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", if_valid); end
        nvec++; if (if_instr !== 32'd0) begin nerr++; $display("FAIL reset_instr got %h want 0", if_instr); end
        nvec++; if (if_pc !== 32'd0) begin nerr++; $display("FAIL reset_pc got %h want 0", if_pc); end
        nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b want 0", halted); end
        nvec++; if (misalign_err !== 1'b0) begin nerr++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
        nvec++; if (imem_addr !== 32'h00013880) begin nerr++; $display("FAIL reset_addr got %h want 00013880", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        nvec++; if (fetch_count !== 32'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", fetch_count); end
`endif
    endtask

    task automatic test_stream_and_halt();
        logic [31:0] exp;
        zero_en = 1'b1; zero_addr = 32'h00013898;
        start = 1'b1;
        step();
        start = 1'b0;
        nvec++; if (if_valid !== 1'b0) begin nerr++; $display("FAIL start_no_fetch got %b want 0", if_valid); end
        for (int i = 0; i < 6; i++) begin
            exp = 32'h00013880 + 32'(4 * i);
            step();
            nvec++; if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== ~exp) begin
                nerr++; $display("FAIL stream_%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, if_valid, if_pc, if_instr, exp, ~exp);
            end
        end
        step();
        nvec++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h00013898) begin
            nerr++; $display("FAIL zero_halt got h=%b v=%b addr=%h want h=1 v=0 addr=00013898", halted, if_valid, imem_addr);
        end
        step();
        step();
        nvec++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h00013898) begin
            nerr++; $display("FAIL halt_hold got h=%b v=%b addr=%h want h=1 v=0 addr=00013898", halted, if_valid, imem_addr);
        end
    endtask

    task automatic test_restart_stall();
        logic [31:0] exp;
        redirect_valid = 1'b1; redirect_pc = 32'h00013880;
        step();
        redirect_valid = 1'b0;
        nvec++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h00013880) begin
            nerr++; $display("FAIL restart got h=%b v=%b addr=%h want h=0 v=0 addr=00013880", halted, if_valid, imem_addr);
        end
        step();
        nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h00013880) begin
            nerr++; $display("FAIL refetch got v=%b pc=%h want v=1 pc=00013880", if_valid, if_pc);
        end
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h00013880 || if_instr !== ~32'h00013880 || imem_addr !== 32'h00013884) begin
                nerr++; $display("FAIL stall_%0d got v=%b pc=%h ins=%h addr=%h want v=1 pc=00013880 addr=00013884", i, if_valid, if_pc, if_instr, imem_addr);
            end
        end
        if_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            exp = 32'h00013880 + 32'(4 * i);
            step();
            nvec++; if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== ~exp) begin
                nerr++; $display("FAIL resume_%0d got v=%b pc=%h want v=1 pc=%h", i, if_valid, if_pc, exp);
            end
        end
        step();
        nvec++; if (halted !== 1'b1 || if_valid !== 1'b0) begin
            nerr++; $display("FAIL rehalt got h=%b v=%b want h=1 v=0", halted, if_valid);
        end
    endtask

    task automatic test_flush_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h00013880;
        step();
        redirect_valid = 1'b0; if_ready = 1'b0;
        step();
        nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h00013880) begin
            nerr++; $display("FAIL held_word got v=%b pc=%h want v=1 pc=00013880", if_valid, if_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h00013886;
        step();
        redirect_valid = 1'b0;
        nvec++; if (if_valid !== 1'b0 || imem_addr !== 32'h00013884 || misalign_err !== 1'b1) begin
            nerr++; $display("FAIL flush got v=%b addr=%h mis=%b want v=0 addr=00013884 mis=1", if_valid, imem_addr, misalign_err);
        end
        if_ready = 1'b1;
        step();
        nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h00013884 || misalign_err !== 1'b1) begin
            nerr++; $display("FAIL post_flush got v=%b pc=%h mis=%b want v=1 pc=00013884 mis=1", if_valid, if_pc, misalign_err);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0;
        nvec++; if (imem_addr !== 32'hFFFFFFFC || if_valid !== 1'b0) begin
            nerr++; $display("FAIL wrap_redirect got addr=%h v=%b want addr=fffffffc v=0", imem_addr, if_valid);
        end
        step();
        nvec++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFFFFFC || if_instr !== 32'h00000003) begin
            nerr++; $display("FAIL wrap_top got pc=%h ins=%h want pc=fffffffc ins=00000003", if_pc, if_instr);
        end
        step();
        nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h00000000 || if_instr !== 32'hFFFFFFFF) begin
            nerr++; $display("FAIL wrap_zero got pc=%h ins=%h want pc=00000000 ins=ffffffff", if_pc, if_instr);
        end
        step();
        nvec++; if (if_pc !== 32'h00000004 || misalign_err !== 1'b1) begin
            nerr++; $display("FAIL wrap_next got pc=%h mis=%b want pc=00000004 mis=1", if_pc, misalign_err);
        end
`ifdef FETCH_PERF_CNT_EN
        nvec++; if (fetch_count !== xfers) begin
            nerr++; $display("FAIL perf_count got %0d want %0d", fetch_count, xfers);
        end
`endif
    endtask

    task automatic test_idle_and_priority();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nvec++; if (if_valid !== 1'b0 || misalign_err !== 1'b0 || imem_addr !== 32'h00013880) begin
            nerr++; $display("FAIL midreset got v=%b mis=%b addr=%h want v=0 mis=0 addr=00013880", if_valid, misalign_err, imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h00000100;
        step();
        redirect_valid = 1'b0;
        step();
        nvec++; if (imem_addr !== 32'h00000100 || if_valid !== 1'b0 || halted !== 1'b0) begin
            nerr++; $display("FAIL idle_redirect got addr=%h v=%b h=%b want addr=00000100 v=0 h=0", imem_addr, if_valid, halted);
        end
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00000200;
        step();
        start = 1'b0; redirect_valid = 1'b0;
        nvec++; if (imem_addr !== 32'h00000200 || if_valid !== 1'b0) begin
            nerr++; $display("FAIL start_redirect got addr=%h v=%b want addr=00000200 v=0", imem_addr, if_valid);
        end
        step();
        nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h00000200) begin
            nerr++; $display("FAIL start_fetch got v=%b pc=%h want v=1 pc=00000200", if_valid, if_pc);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        nvec++; if (if_pc !== 32'h00000204 || halted !== 1'b0) begin
            nerr++; $display("FAIL start_in_run got pc=%h h=%b want pc=00000204 h=0", if_pc, halted);
        end
        reset = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00000500;
        step();
        reset = 1'b0; start = 1'b0; redirect_valid = 1'b0;
        nvec++; if (imem_addr !== 32'h00013880 || if_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_priority got addr=%h v=%b want addr=00013880 v=0", imem_addr, if_valid);
        end
        step();
        nvec++; if (if_valid !== 1'b0 || imem_addr !== 32'h00013880) begin
            nerr++; $display("FAIL stay_idle got v=%b addr=%h want v=0 addr=00013880", if_valid, imem_addr);
        end
    endtask

    initial begin
        nvec = 0; nerr = 0; xfers = 0;
        zero_en = 1'b0; zero_addr = 32'd0;
        reset = 1'b1; start = 1'b0; if_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_stream_and_halt();
        test_restart_stall();
        test_flush_misalign();
        test_wrap();
        test_idle_and_priority();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h00013880, is the program counter value loaded on reset.
REQ-002 Parameter HALT_ON_ZERO, default 1: when 1, a fetched all-zero word halts fetch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that moves the controller from IDLE to RUN.
REQ-006 imem_addr  output  32  address to the combinational instruction memory; equals the internal PC at all times.
REQ-007 imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-008 if_valid  output  1  the output register holds an instruction for decode.
REQ-009 if_instr  output  32  registered instruction word.
REQ-010 if_pc  output  32  address from which if_instr was fetched.
REQ-011 if_ready  input  1  decode accepts if_instr; a transfer occurs when if_valid and if_ready are both 1.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_pc  input  32  redirect target.
REQ-014 halted  output  1  high while in HALT.
REQ-015 misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-016 States are IDLE, RUN and HALT, encoded in a 2-bit register.
REQ-017 IDLE -> RUN on start; RUN -> HALT on zero-word detection (REQ-021); HALT -> RUN on redirect_valid; IDLE is left only by start.
REQ-018 In RUN, a fetch occurs when the output register is empty or being transferred in the same cycle: if_instr<=imem_data, if_pc<=PC, if_valid<=1, PC<=PC+4.
REQ-019 Throughput: one instruction per cycle while if_ready=1; latency from PC to if_valid is one cycle.
REQ-020 If if_valid=1 and if_ready=0, PC, if_instr and if_pc hold and no fetch occurs.
REQ-021 With HALT_ON_ZERO=1, a fetch that reads imem_data==0 is not delivered: if_valid<=0 (unless a held word remains untransferred), PC holds, state<=HALT.
REQ-022 PC+4 wraps modulo 2^32; 32'hFFFFFFFC advances to 0 with no flag.
REQ-023 redirect_valid has priority over fetch in every state: PC<={redirect_pc[31:2],2'b00}, if_valid<=0, and no fetch in that cycle.
REQ-024 A word transferred in the same cycle as a redirect counts as consumed; an untransferred word is flushed.
REQ-025 A redirect in IDLE updates PC and stays in IDLE; start with redirect in the same cycle loads the redirect PC and enters RUN.
REQ-026 misalign_err<=1 when redirect_valid and redirect_pc[1:0]!=0; it clears only on reset.
REQ-027 In IDLE and HALT no fetch occurs; a word already held in the output register is still delivered on handshake.
REQ-028 start is ignored in RUN and HALT.

Reset
REQ-029 On reset: state=IDLE, PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, misalign_err=0, fetch_count=0.
REQ-030 Reset mid-operation discards any held instruction; reset has priority over start and redirect_valid.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN: when defined, add output fetch_count [31:0], which increments by 1 per transfer and wraps at 2^32; when undefined, the port and the counter are absent and all other behaviour is identical.

Verification
REQ-032 Reset, start, memory returns nonzero words at 0x13880..0x13894, if_ready=1 -> six consecutive transfers with if_pc 0x13880,0x13884,...,0x13894, one per cycle.
REQ-033 if_ready=0 for 3 cycles after the first valid -> if_instr/if_pc stable, imem_addr stays 0x13884, then streaming resumes without a gap or duplicate.
REQ-034 Word at 0x13898 reads 0 -> no transfer of it, halted=1, imem_addr=0x13898; redirect to 0x13880 -> halted=0, refetch from 0x13880.
REQ-035 Redirect to 0x13886 while a word is held with if_ready=0 -> held word flushed, imem_addr=0x13884 next cycle, misalign_err=1 until reset.
REQ-036 Redirect to 0xFFFFFFFC, nonzero memory -> if_pc sequence 0xFFFFFFFC then 0x00000000; with FETCH_PERF_CNT_EN, fetch_count equals the number of transfers.
